// File: rtl/mem_copy_engine.sv
// Block-copy initiator for a single-port synchronous RAM: reads one word, writes it, repeats.
// Each word takes one read cycle and one write cycle; abort ends the block early.
module mem_copy_engine #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W-1:0] len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W-1:0] remaining,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rw,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [1:0]        dbg_state
);

   // Handshake: start is a one-cycle request honoured only in IDLE; there is no
   // ready back-pressure, the caller watches busy and waits for the done pulse.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] cur_src;
   logic [ADDR_W-1:0] cur_dst;
   logic [ADDR_W-1:0] rem_dec;

   assign rem_dec   = remaining - ADDR_W'(1);
   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = (len != '0) ? S_RD : S_DONE;
            end
         end
         S_RD: begin
            state_nx = abort ? S_DONE : S_WR;
         end
         S_WR: begin
            state_nx = ((rem_dec == '0) || abort) ? S_DONE : S_RD;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Pointers wrap modulo 2^ADDR_W; the write in WR always retires before abort takes effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_src   <= '0;
         cur_dst   <= '0;
         remaining <= '0;
         aborted   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cur_src   <= src;
                  cur_dst   <= dst;
                  remaining <= len;
                  aborted   <= 1'b0;
               end
            end
            S_RD: begin
               if (abort) begin
                  aborted <= 1'b1;
               end
            end
            S_WR: begin
               cur_src   <= cur_src + ADDR_W'(1);
               cur_dst   <= cur_dst + ADDR_W'(1);
               remaining <= rem_dec;
               aborted   <= abort;
            end
            default: begin
               aborted <= aborted;
            end
         endcase
      end
   end

   // Decoded straight from state so reset forces ram_rw low without waiting for an edge.
   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      ram_rw    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         S_RD: begin
            ram_addr = cur_src;
         end
         S_WR: begin
            ram_addr  = cur_dst;
            ram_rw    = 1'b1;
            ram_wdata = ram_rdata;
         end
         default: begin
            ram_addr = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a 256-word RAM, directed and random copies,
// compared against a word-by-word forward-copy reference model.
module tb_mem_copy_engine;

   localparam int RAM_N = 256;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] src;
   logic [15:0] dst;
   logic [15:0] len;
   logic        abort;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [15:0] remaining;
   logic [15:0] ram_addr;
   logic        ram_rw;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic [1:0]  dbg_state;

   logic [15:0] mem [RAM_N];
   logic [15:0] ref_mem [RAM_N];
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [15:0] ld_data;

   int n_checks;
   int n_fail;
   int spurious;

   mem_copy_engine #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src       (src),
      .dst       (dst),
      .len       (len),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .remaining (remaining),
      .ram_addr  (ram_addr),
      .ram_rw    (ram_rw),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM: registered read, out-of-range reads return 0, out-of-range writes dropped
   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (ram_rw && ram_addr < RAM_N) begin
         mem[ram_addr[7:0]] <= ram_wdata;
      end
      ram_rdata <= (ram_addr < RAM_N) ? mem[ram_addr[7:0]] : 16'h0000;
   end

   // a write strobe outside the write phase of a copy is always an error
   always @(negedge clk) begin
      if (ram_rw && (rst || !busy || done)) spurious++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [15:0] v);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = v;
      ref_mem[a] = v;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // reference: words copied one at a time in ascending order, so overlap propagates forward
   task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int words);
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] v;
      for (int i = 0; i < words; i++) begin
         a = s + 16'(i);
         b = d + 16'(i);
         v = (a < RAM_N) ? ref_mem[a[7:0]] : 16'h0000;
         if (b < RAM_N) ref_mem[b[7:0]] = v;
      end
   endtask

   task automatic compare_mem();
      for (int i = 0; i < RAM_N; i++) begin
         check_eq($sformatf("mem[%0h]", i), mem[i], ref_mem[i]);
      end
   endtask

   // ab_kind: 0 none, 1 abort in ab_num-th read, 2 abort in ab_num-th write
   task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                           input int ab_kind, input int ab_num, input bit busy_start);
      int idx, rd_n, wr_n, words, exp_idx;
      bit got_done;
      logic [15:0] ea;
      case (ab_kind)
         1:       begin words = ab_num - 1; exp_idx = 2 * words + 2; end
         2:       begin words = ab_num;     exp_idx = 2 * words + 1; end
         default: begin words = int'(l);    exp_idx = 2 * words + 1; end
      endcase
      @(negedge clk);
      start = 1'b1; src = s; dst = d; len = l;
      @(negedge clk);
      start = 1'b0; src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
      idx = 0; rd_n = 0; wr_n = 0; got_done = 1'b0;
      while (!got_done && idx < 2 * int'(l) + 8) begin
         idx++;
         abort = 1'b0;
         start = 1'b0;
         if (done) begin
            got_done = 1'b1;
            check_eq("done_cycle", idx, exp_idx);
            check_eq("aborted", aborted, (ab_kind != 0) ? 1 : 0);
            check_eq("remaining", remaining, 32'(int'(l) - words));
            check_eq("busy_in_done", busy, 1);
            check_eq("rw_in_done", ram_rw, 0);
         end else if (busy) begin
            if (ram_rw) begin
               wr_n++;
               ea = d + 16'(wr_n - 1);
               check_eq("wr_addr", ram_addr, ea);
               if (ab_kind == 2 && wr_n == ab_num) abort = 1'b1;
            end else begin
               rd_n++;
               ea = s + 16'(rd_n - 1);
               check_eq("rd_addr", ram_addr, ea);
               if (ab_kind == 1 && rd_n == ab_num) abort = 1'b1;
            end
            if (busy_start && idx == 3) begin
               start = 1'b1; src = 16'h0000; dst = 16'h00F0; len = 16'h0001;
            end
         end else begin
            check_eq("busy_early_drop", busy, 1);
         end
         if (!got_done) @(negedge clk);
      end
      abort = 1'b0;
      start = 1'b0;
      check_eq("done_seen", got_done, 1);
      check_eq("write_count", wr_n, words);
      @(negedge clk);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_done", done, 0);
      model_copy(s, d, words);
      compare_mem();
   endtask

   // reset asserted mid-way through the k-th write; that write must not land
   task automatic run_reset(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input int k);
      int idx, wr_n;
      bit hit;
      @(negedge clk);
      start = 1'b1; src = s; dst = d; len = l;
      @(negedge clk);
      start = 1'b0;
      idx = 0; wr_n = 0; hit = 1'b0;
      while (!hit && idx < 2 * int'(l) + 8) begin
         idx++;
         if (ram_rw) wr_n++;
         if (ram_rw && wr_n == k) hit = 1'b1;
         else @(negedge clk);
      end
      check_eq("rst_reached_wr", hit, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_rw", ram_rw, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_remaining", remaining, 0);
      check_eq("rst_addr", ram_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      model_copy(s, d, k - 1);
      compare_mem();
   endtask

   initial begin
      int l, kind, num;
      logic [15:0] s, d;
      n_checks = 0; n_fail = 0; spurious = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      src = '0; dst = '0; len = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      #1;
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_aborted", aborted, 0);
      check_eq("reset_remaining", remaining, 0);
      check_eq("reset_addr", ram_addr, 0);
      check_eq("reset_rw", ram_rw, 0);
      check_eq("reset_wdata", ram_wdata, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < RAM_N; i++) poke(8'(i), 16'($urandom));

      // basic 4-word copy
      poke(8'h10, 16'h00A1); poke(8'h11, 16'h00B2);
      poke(8'h12, 16'h00C3); poke(8'h13, 16'h00D4);
      run_copy(16'h0010, 16'h0040, 16'd4, 0, 0, 1'b0);
      check_eq("copy_w0", mem[8'h40], 16'h00A1);
      check_eq("copy_w3", mem[8'h43], 16'h00D4);

      // zero length
      run_copy(16'h0010, 16'h0020, 16'd0, 0, 0, 1'b0);

      // pattern fill via overlapping forward copy
      poke(8'h50, 16'h5A5A);
      run_copy(16'h0050, 16'h0051, 16'd8, 0, 0, 1'b0);
      for (int i = 8'h51; i <= 8'h58; i++) check_eq("fill", mem[i], 16'h5A5A);

      // address wrap: reads at FFFE, FFFF are out of range, then 0000
      run_copy(16'hFFFE, 16'h0080, 16'd3, 0, 0, 1'b0);
      check_eq("wrap_w0", mem[8'h80], 16'h0000);
      check_eq("wrap_w1", mem[8'h81], 16'h0000);
      check_eq("wrap_w2", mem[8'h82], mem[0]);

      // abort in 2nd read, then in 3rd write
      run_copy(16'h0020, 16'h00A0, 16'd5, 1, 2, 1'b0);
      run_copy(16'h0030, 16'h00B0, 16'd5, 2, 3, 1'b0);

      // reset mid-copy, then a normal copy; then start while busy
      run_reset(16'h0060, 16'h00C0, 16'd6, 2);
      run_copy(16'h0060, 16'h00C0, 16'd6, 0, 0, 1'b0);
      run_copy(16'h0070, 16'h00D0, 16'd5, 0, 0, 1'b1);

      // random copies with random abort placement
      for (int t = 0; t < 30; t++) begin
         l = $urandom_range(0, 12);
         s = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF4, 16'hFFFF))
                                         : 16'($urandom_range(0, RAM_N - 1));
         d = 16'($urandom_range(0, RAM_N - 1));
         kind = (l == 0) ? 0 : $urandom_range(0, 2);
         num = (kind == 0) ? 0 : $urandom_range(1, l);
         run_copy(s, d, 16'(l), kind, num, (l >= 3) ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      check_eq("spurious_writes", spurious, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
